// File: rtl/pc16_pkg.sv
// Shared constants and action encoding for the pc16 program counter.
// The bench imports the same encoding to derive expected behaviour.
package pc16_pkg;
  localparam int          PC_WIDTH       = 16;
  localparam logic [15:0] PC_RESET_VALUE = 16'h0000;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } pc_op_e;

  // Fixed priority: clr > load > inc > hold.
  function automatic pc_op_e pc_sel_op(input logic clr, input logic load, input logic inc);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction
endpackage

// File: rtl/pc16_if.sv
// Control/data bundle between the datapath (master) and the counter (slave).
interface pc16_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] d;
  logic             clr;
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] pc;
  logic             wrap;
  logic             loaded;

  modport master (output d, clr, load, inc, input  pc, wrap, loaded);
  modport slave  (input  d, clr, load, inc, output pc, wrap, loaded);
endinterface

// File: rtl/pc16_mux16.sv
// Two-input WIDTH-bit mux; used as the building block of the next-pc select.
module mux16 #(
  parameter int WIDTH = 16
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/pc16_register16.sv
// WIDTH-bit register with enable and async active-low reset to RESET_VALUE.
module register16 #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= RESET_VALUE;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/pc16.sv
// Program counter: clr > load > inc > hold, with registered wrap/loaded pulses.
module pc16
  import pc16_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input  logic  clk,
  input  logic  rst_n,
  pc16_if.slave bus
);
  pc_op_e           op;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] m_inc;
  logic [WIDTH-1:0] m_load;
  logic [WIDTH-1:0] pc_d;
  logic             wrap_d,   wrap_q;
  logic             loaded_d, loaded_q;

  assign op     = pc_sel_op(bus.clr, bus.load, bus.inc);
  assign pc_inc = pc_q + WIDTH'(1);

  // Mux chain mirrors the priority; d only reaches pc_d when load selects it.
  mux16 #(.WIDTH(WIDTH)) u_mux_inc  (.sel_i(bus.inc),  .a_i(pc_q),   .b_i(pc_inc),      .y_o(m_inc));
  mux16 #(.WIDTH(WIDTH)) u_mux_load (.sel_i(bus.load), .a_i(m_inc),  .b_i(bus.d),       .y_o(m_load));
  mux16 #(.WIDTH(WIDTH)) u_mux_clr  (.sel_i(bus.clr),  .a_i(m_load), .b_i(RESET_VALUE), .y_o(pc_d));

  register16 #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (op != OP_HOLD),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  always_comb begin
    wrap_d   = 1'b0;
    loaded_d = 1'b0;
    case (op)
      OP_INC:  wrap_d   = &pc_q;
      OP_LOAD: loaded_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      wrap_q   <= wrap_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.wrap   = wrap_q;
  assign bus.loaded = loaded_q;
endmodule
